fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch front end feeding the core's fetch port (pc in; instruction/valid out).
//  Holds a 2-entry tagged instruction buffer and issues word reads to instruction memory
//  over a valid/ready request channel and an in-order response channel.
//  Sequential prefetch of pc+4 hides memory latency on straight-line code.
//  flush (fence.i) invalidates all buffered words.
// PARAMETERS
//  RESET_PC  32'h0000_0000  informational only; no cold prefetch is issued at reset
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   reset; synchronous, active-high
//  pc             in   32  fetch address from core (core holds it stable while valid=0)
//  instruction    out  32  instruction word for pc
//  valid          out  1   instruction is the word at pc
//  flush          in   1   invalidate buffer; drop the in-flight response
//  mem_req_valid  out  1   read request
//  mem_req_addr   out  32  word-aligned request address
//  mem_req_ready  in   1   request accepted when valid&&ready
//  mem_resp_valid in   1   read data returned; in order, 1 per accepted request
//  mem_resp_data  in   32  read data
// BEHAVIOUR
//  - Tags are addr[31:2]; pc[1:0] ignored. Entry e: {v, tag, data}.
//  - hit = some e.v && e.tag==pc[31:2]. Combinational: valid=hit, instruction=hit data, else 0.
//  - No fill-to-output bypass: a word is usable the cycle after its response.
//  - At most one outstanding request. States:
//    IDLE -> REQ when a target exists; REQ -> WAIT on valid&&ready; WAIT -> IDLE on mem_resp_valid.
//    REQ holds mem_req_valid=1 and mem_req_addr from a register latched on IDLE->REQ; both stable until accepted.
//  - Target chosen in IDLE:
//    * pc misses: addr = {pc[31:2],2'b00}.
//    * pc hits and pc+4 misses: addr = pc+4 (prefetch), wrapping modulo 2^32.
//    * otherwise: no request; stay IDLE.
//  - Fill on response:
//    * Victim is the entry not hit by the current pc. If neither entry hits, victim is a 1-bit round-robin pointer, toggled on every fill.
//    * Written: v=1, tag=request tag, data=mem_resp_data.
//    * A stale tag (pc has moved) is still written; tags keep it correct.
//  - Branch during WAIT: wait for the response, fill, then re-evaluate pc in IDLE. No cancel.
//  - flush:
//    * All v cleared next cycle.
//    * In WAIT, set drop flag: the response is consumed and not written, drop is cleared, FSM -> IDLE.
//    * In REQ, the request is still presented until accepted (no retraction), then handled as WAIT+drop.
//    * flush takes priority over a same-cycle fill.
//  - Same-cycle mem_resp_valid and new-target selection: fill this cycle; issue next cycle from IDLE.
//  - mem_resp_valid in IDLE/REQ (protocol error): ignored. Assertion fires in simulation.
//  - Reset:
//    * Values: state=IDLE, all v=0, drop=0, rr=0, mem_req_valid=0, mem_req_addr=0.
//    * Outputs: valid=0, instruction=0.
//    * Reset mid-WAIT abandons the request. Memory must also be reset.
//  - Miss latency with ready=1, resp k cycles after acceptance: miss seen at cycle t; req at t+1; resp at t+1+k; valid at t+2+k.
// STRUCTURE
//  - fetch_pkg:
//    * typedef enum logic[1:0] {FS_IDLE, FS_REQ, FS_WAIT} fetch_state_t;
//    * typedef struct packed {logic v; logic [29:0] tag; logic [31:0] data;} fetch_entry_t;
//    * localparam FETCH_ENTRIES=2.
//  - Sub-module fetch_buffer: 2-entry tag store with lookup ports (pc, pc+4), fill port, victim select, flush.
//  - fetch_unit: FSM, request register, drop flag, output mux.
// TESTING
//  1. Cold miss: reset, pc=0, ready=1, mem returns 0x00500093 1 cycle after accept -> req addr 0 at cycle 1; valid=1, instruction=0x00500093 at cycle 3.
//  2. Prefetch: after test 1, pc held at 0 -> next request addr 4. Then pc=4 -> valid the same cycle, and request addr 8 issued.
//  3. Stall hold: pc held at 4 for 10 cycles -> valid stays 1 and instruction constant; no request beyond the addr-8 prefetch.
//  4. Backpressure: ready=0 for 5 cycles on a miss at pc=0x100 -> mem_req_valid=1 and addr=0x100 stable throughout; exactly one accept.
//  5. Branch mid-WAIT: prefetch of 8 outstanding, pc jumps to 0x200 -> addr-8 data filled, then request 0x200 issued. Return to pc=8 -> hit with no request.
//  6. Flush mid-WAIT: flush while request to 0x40 outstanding -> response dropped, buffer empty, valid=0; re-request 0x40 issued after the response.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_state_t  request FSM states (idle, presenting request, awaiting response)
//   fetch_entry_t  one buffered instruction word: valid bit, word tag (addr[31:2]), data
//   FETCH_ENTRIES  number of buffer entries
//   word_tag()     word tag of a byte address
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        v;
    logic [29:0] tag;
    logic [31:0] data;
  } fetch_entry_t;

  localparam int FETCH_ENTRIES = 2;

  function automatic logic [29:0] word_tag(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry tagged instruction store.
//   clk, rst       clock / synchronous active-high reset (clears valid bits and pointer)
//   i_pc_tag       tag looked up for the current fetch address
//   i_nxt_tag      tag looked up for the sequential successor (prefetch candidate)
//   i_fill         write i_fill_tag / i_fill_data into the victim entry
//   i_flush        invalidate every entry; wins over a same-cycle fill
//   o_pc_hit       current fetch address is buffered
//   o_nxt_hit      successor address is buffered
//   o_pc_data      data of the hitting entry, zero on a miss
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_pc_tag,
  input  logic [29:0] i_nxt_tag,
  input  logic        i_fill,
  input  logic [29:0] i_fill_tag,
  input  logic [31:0] i_fill_data,
  input  logic        i_flush,
  output logic        o_pc_hit,
  output logic        o_nxt_hit,
  output logic [31:0] o_pc_data
);

  fetch_entry_t               r_ent [FETCH_ENTRIES];
  logic                       r_rr;
  logic [FETCH_ENTRIES-1:0]   w_pc_hit_vec;
  logic [FETCH_ENTRIES-1:0]   w_nxt_hit_vec;
  logic                       w_victim;

  always_comb begin
    w_pc_hit_vec  = '0;
    w_nxt_hit_vec = '0;
    o_pc_data     = '0;
    for (int i = 0; i < FETCH_ENTRIES; i++) begin
      w_pc_hit_vec[i]  = r_ent[i].v && (r_ent[i].tag == i_pc_tag);
      w_nxt_hit_vec[i] = r_ent[i].v && (r_ent[i].tag == i_nxt_tag);
      if (w_pc_hit_vec[i]) begin
        o_pc_data = r_ent[i].data;
      end
    end
  end

  assign o_pc_hit  = |w_pc_hit_vec;
  assign o_nxt_hit = |w_nxt_hit_vec;

  // Never evict the word the core is currently executing from; with no
  // hit, alternate between the entries.
  always_comb begin
    if (w_pc_hit_vec[0]) begin
      w_victim = 1'b1;
    end else if (w_pc_hit_vec[1]) begin
      w_victim = 1'b0;
    end else begin
      w_victim = r_rr;
    end
  end

  // Tag and data fields are deliberately left unreset; only valid bits matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent[0].v <= 1'b0;
      r_ent[1].v <= 1'b0;
      r_rr       <= 1'b0;
    end else if (i_flush) begin
      r_ent[0].v <= 1'b0;
      r_ent[1].v <= 1'b0;
    end else if (i_fill) begin
      r_ent[w_victim] <= '{v: 1'b1, tag: i_fill_tag, data: i_fill_data};
      r_rr            <= ~r_rr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with a 2-entry buffer and pc+4 prefetch.
//   clk, rst        clock / synchronous active-high reset
//   pc              fetch address from the core (bits [1:0] ignored)
//   instruction     buffered word at pc, zero when not buffered
//   valid           instruction holds the word at pc
//   flush           invalidate buffer and discard any in-flight response
//   mem_req_valid   read request to instruction memory (held until accepted)
//   mem_req_addr    word-aligned request address
//   mem_req_ready   memory accepts the request when valid && ready
//   mem_resp_valid  in-order read response, one per accepted request
//   mem_resp_data   read data
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  // RESET_PC is descriptive only (no cold prefetch), but it must be word aligned.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word aligned");
  end

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_req_addr;
  logic         r_drop;
  logic         w_drop_nxt;
  logic         w_latch;
  logic         w_fill;
  logic [29:0]  w_pc_tag;
  logic [29:0]  w_nxt_tag;
  logic         w_pc_hit;
  logic         w_nxt_hit;
  logic [31:0]  w_pc_data;
  logic         w_target_vld;
  logic [31:0]  w_target_addr;
  logic         w_unused;

  // Byte offset of pc never selects anything; the +1 on the word tag wraps
  // modulo 2^32 exactly like pc+4.
  assign w_pc_tag  = word_tag(pc);
  assign w_nxt_tag = w_pc_tag + 30'd1;
  assign w_unused  = ^pc[1:0];

  fetch_buffer u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_pc_tag    (w_pc_tag),
    .i_nxt_tag   (w_nxt_tag),
    .i_fill      (w_fill),
    .i_fill_tag  (word_tag(r_req_addr)),
    .i_fill_data (mem_resp_data),
    .i_flush     (flush),
    .o_pc_hit    (w_pc_hit),
    .o_nxt_hit   (w_nxt_hit),
    .o_pc_data   (w_pc_data)
  );

  // Demand miss first; otherwise prefetch the sequential successor.
  assign w_target_vld  = !w_pc_hit || !w_nxt_hit;
  assign w_target_addr = !w_pc_hit ? {w_pc_tag, 2'b00} : {w_nxt_tag, 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_latch     = 1'b0;
    w_fill      = 1'b0;
    unique case (r_state)
      FS_IDLE: begin
        // Targets are chosen from contents that a flush is about to clear,
        // so selection waits a cycle.
        if (w_target_vld && !flush) begin
          w_latch     = 1'b1;
          w_state_nxt = FS_REQ;
        end
      end
      FS_REQ: begin
        // A request cannot be retracted; its response is discarded instead.
        if (flush) begin
          w_drop_nxt = 1'b1;
        end
        if (mem_req_ready) begin
          w_state_nxt = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (mem_resp_valid) begin
          w_fill      = !r_drop && !flush;
          w_drop_nxt  = 1'b0;
          w_state_nxt = FS_IDLE;
        end else if (flush) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FS_IDLE;
      r_drop     <= 1'b0;
      r_req_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_latch) begin
        r_req_addr <= w_target_addr;
      end
    end
  end

  assign mem_req_valid = (r_state == FS_REQ);
  assign mem_req_addr  = r_req_addr;
  assign valid         = w_pc_hit;
  assign instruction   = w_pc_data;

  a_resp_only_in_wait: assert property (
    @(posedge clk) disable iff (rst) mem_resp_valid |-> (r_state == FS_WAIT)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int vectors    = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .instruction    (instruction),
    .valid          (valid),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0) return 32'h0050_0093;
    return (w ^ 32'hDEAD_0000) + 32'h0000_0013;
  endfunction

  // ---------------- memory responder ----------------
  int          lat = 1;
  int          cnt = 0;
  int          n_acc = 0;
  logic [31:0] resp_addr = '0;
  logic [31:0] last_acc_addr = '0;

  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_word(resp_addr);
        end
      end
      @(negedge clk);
      if (rst) begin
        cnt = 0;
      end else if (mem_req_valid && mem_req_ready) begin
        resp_addr     = mem_req_addr;
        last_acc_addr = mem_req_addr;
        cnt           = lat;
        n_acc         = n_acc + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Resident words: a set of at most two word tags. Request life cycle:
  // 0 = nothing outstanding, 1 = request offered, 2 = accepted, awaiting data.
  logic [29:0] m_tag [2] = '{30'h0, 30'h0};
  logic        m_res [2] = '{1'b0, 1'b0};
  int          m_rr    = 0;
  int          m_phase = 0;
  logic [31:0] m_addr  = '0;
  logic        m_drop  = 1'b0;

  logic        exp_valid;
  logic [31:0] exp_instr;
  logic        exp_req_valid;
  logic [31:0] exp_req_addr;

  function automatic int m_find(input logic [29:0] t);
    for (int i = 0; i < 2; i++) if (m_res[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  task automatic settle();
    @(negedge clk);
    exp_valid     = (m_find(pc[31:2]) >= 0);
    exp_instr     = exp_valid ? mem_word(pc) : 32'h0;
    exp_req_valid = (m_phase == 1);
    exp_req_addr  = m_addr;
  endtask

  task automatic advance();
    int          h;
    int          vic;
    logic [29:0] nt;
    if (rst) begin
      m_res   = '{1'b0, 1'b0};
      m_rr    = 0;
      m_phase = 0;
      m_addr  = '0;
      m_drop  = 1'b0;
    end else begin
      h  = m_find(pc[31:2]);
      nt = pc[31:2] + 30'd1;
      if (m_phase == 0) begin
        if (!flush) begin
          if (h < 0) begin
            m_addr = {pc[31:2], 2'b00}; m_phase = 1;
          end else if (m_find(nt) < 0) begin
            m_addr = {nt, 2'b00}; m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (flush) m_drop = 1'b1;
        if (mem_req_ready) m_phase = 2;
      end else begin
        if (mem_resp_valid) begin
          if (!m_drop && !flush) begin
            vic = (h >= 0) ? 1 - h : m_rr;
            m_tag[vic] = m_addr[31:2];
            m_res[vic] = 1'b1;
            m_rr = 1 - m_rr;
          end
          m_drop  = 1'b0;
          m_phase = 0;
        end else if (flush) begin
          m_drop = 1'b1;
        end
      end
      if (flush) m_res = '{1'b0, 1'b0};
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; pc = '0; flush = 1'b0; mem_req_ready = 1'b0; lat = 1;
    repeat (2) begin settle(); advance(); end
    settle();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instruction); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL reset_req_addr: got %h want 0", mem_req_addr); end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    pc = 32'h0; mem_req_ready = 1'b1; lat = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (c == 0) begin
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL cold_c0_req: got %b want 0", mem_req_valid); end
      end
      if (c == 1) begin
        vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL cold_c1_req: got %b want 1", mem_req_valid); end
        vectors++; if (mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL cold_c1_addr: got %h want 0", mem_req_addr); end
      end
      if (c == 2) begin
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL cold_no_bypass: got %b want 0", valid); end
      end
      if (c == 3) begin
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL cold_c3_valid: got %b want 1", valid); end
        vectors++; if (instruction !== 32'h0050_0093) begin miscompares++; $display("FAIL cold_c3_instr: got %h want 00500093", instruction); end
      end
      advance();
    end
  endtask

  int n_mark;

  task automatic test_prefetch();
    bit found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      settle();
      if (mem_req_valid) begin
        found = 1;
        vectors++; if (mem_req_addr !== 32'h4) begin miscompares++; $display("FAIL prefetch_addr4: got %h want 4", mem_req_addr); end
      end
      advance();
    end
    if (!found) begin vectors++; miscompares++; $display("FAIL prefetch_timeout: got no request want addr 4"); end
    repeat (3) begin settle(); advance(); end
    n_mark = n_acc;
    pc = 32'h4;
    settle();
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL prefetch_hit4: got %b want 1", valid); end
    vectors++; if (instruction !== mem_word(32'h4)) begin miscompares++; $display("FAIL prefetch_instr4: got %h want %h", instruction, mem_word(32'h4)); end
    advance();
    settle();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8) begin
      miscompares++; $display("FAIL prefetch_addr8: got v=%b a=%h want v=1 a=00000008", mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) settle();
      vectors++; if (valid !== 1'b1 || instruction !== mem_word(32'h4)) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got v=%b i=%h want v=1 i=%h", i, valid, instruction, mem_word(32'h4));
      end
      advance();
    end
    vectors++; if (n_acc - n_mark !== 1) begin miscompares++; $display("FAIL stall_accepts: got %0d want 1", n_acc - n_mark); end
    vectors++; if (last_acc_addr !== 32'h8) begin miscompares++; $display("FAIL stall_last_addr: got %h want 8", last_acc_addr); end
  endtask

  task automatic test_backpressure();
    mem_req_ready = 1'b0; pc = 32'h100; n_mark = n_acc;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (i >= 1) begin
        vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
          miscompares++; $display("FAIL bp_hold[%0d]: got v=%b a=%h want v=1 a=00000100", i, mem_req_valid, mem_req_addr);
        end
      end
      advance();
    end
    mem_req_ready = 1'b1;
    settle();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
      miscompares++; $display("FAIL bp_release: got v=%b a=%h want v=1 a=00000100", mem_req_valid, mem_req_addr);
    end
    advance();
    settle(); advance();
    settle();
    vectors++; if (n_acc - n_mark !== 1) begin miscompares++; $display("FAIL bp_accepts: got %0d want 1", n_acc - n_mark); end
    vectors++; if (valid !== 1'b1 || instruction !== mem_word(32'h100)) begin
      miscompares++; $display("FAIL bp_fill: got v=%b i=%h want v=1 i=%h", valid, instruction, mem_word(32'h100));
    end
    advance();
    repeat (6) begin settle(); advance(); end
  endtask

  task automatic test_branch();
    bit found = 0;
    bit bad = 0;
    lat = 3; pc = 32'h4;
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      if (mem_req_valid && mem_req_ready && mem_req_addr == 32'h8) found = 1;
      advance();
    end
    if (!found) begin vectors++; miscompares++; $display("FAIL branch_pref8_timeout: got no request want addr 8"); end
    pc = 32'h200;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      settle();
      if (mem_req_valid) begin
        found = 1;
        vectors++; if (mem_req_addr !== 32'h200) begin miscompares++; $display("FAIL branch_addr200: got %h want 200", mem_req_addr); end
      end
      advance();
    end
    if (!found) begin vectors++; miscompares++; $display("FAIL branch_req_timeout: got no request want addr 200"); end
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      settle();
      if (mem_resp_valid) found = 1;
      advance();
    end
    if (!found) begin vectors++; miscompares++; $display("FAIL branch_resp_timeout: got no response want one"); end
    pc = 32'h8;
    settle();
    vectors++; if (valid !== 1'b1 || instruction !== mem_word(32'h8)) begin
      miscompares++; $display("FAIL branch_back8: got v=%b i=%h want v=1 i=%h", valid, instruction, mem_word(32'h8));
    end
    advance();
    for (int i = 0; i < 8; i++) begin
      settle();
      if (mem_req_valid && mem_req_addr == 32'h8) bad = 1;
      advance();
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL branch_refetch8: got refetch=%b want 0", bad); end
  endtask

  task automatic test_flush();
    bit found = 0;
    lat = 3; pc = 32'h40;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      if (mem_req_valid && mem_req_ready && mem_req_addr == 32'h40) found = 1;
      advance();
    end
    if (!found) begin vectors++; miscompares++; $display("FAIL flush_req_timeout: got no request want addr 40"); end
    pc = 32'h8; flush = 1'b1;
    settle();
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL flush_same_cycle: got %b want 1", valid); end
    advance();
    flush = 1'b0;
    settle();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL flush_cleared: got %b want 0", valid); end
    advance();
    pc = 32'h40;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      settle();
      if (mem_resp_valid) found = 1;
      advance();
    end
    if (!found) begin vectors++; miscompares++; $display("FAIL flush_resp_timeout: got no response want one"); end
    settle();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped: got %b want 0", valid); end
    advance();
    settle();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin
      miscompares++; $display("FAIL flush_rereq: got v=%b a=%h want v=1 a=00000040", mem_req_valid, mem_req_addr);
    end
    advance();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      if (valid) begin
        found = 1;
        vectors++; if (instruction !== mem_word(32'h40)) begin miscompares++; $display("FAIL flush_refill: got %h want %h", instruction, mem_word(32'h40)); end
      end
      advance();
    end
    if (!found) begin vectors++; miscompares++; $display("FAIL flush_refill_timeout: got valid=0 want 1"); end
  endtask

  task automatic test_random();
    logic [31:0] pcs [8];
    pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pc = pcs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      mem_req_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 29) == 0);
      rst           = ($urandom_range(0, 149) == 0);
      lat           = $urandom_range(1, 4);
      settle();
      vectors++; if (valid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b want %b pc=%h", i, valid, exp_valid, pc); end
      vectors++; if (instruction !== exp_instr) begin miscompares++; $display("FAIL rnd_instr[%0d]: got %h want %h pc=%h", i, instruction, exp_instr, pc); end
      vectors++; if (mem_req_valid !== exp_req_valid) begin miscompares++; $display("FAIL rnd_req_valid[%0d]: got %b want %b", i, mem_req_valid, exp_req_valid); end
      if (exp_req_valid) begin
        vectors++; if (mem_req_addr !== exp_req_addr) begin miscompares++; $display("FAIL rnd_req_addr[%0d]: got %h want %h", i, mem_req_addr, exp_req_addr); end
      end
      advance();
    end
    rst = 1'b0; flush = 1'b0; mem_req_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_prefetch();
    test_stall();
    test_backpressure();
    test_branch();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
